// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, fixed WIDTH-cycle latency,
// optional two's-complement operands handled as sign + magnitude.
//   state | meaning
//   IDLE  | waiting for an operand set, in_ready high
//   CALC  | WIDTH cycles of shift-and-add on the captured magnitudes
//   DONE  | product valid, held until out_ready
module seq_shift_add_multiplier #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic            neg_q, neg_d;

    logic            mode_signed;
    logic            a_neg;
    logic            b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]   acc_sum;

    always_comb begin
        mode_signed = SIGNED_EN && signed_mode;
        a_neg       = mode_signed && a[WIDTH-1];
        b_neg       = mode_signed && b[WIDTH-1];
        // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
        a_mag       = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag       = b_neg ? (~b + WIDTH'(1)) : b;
        acc_sum     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        neg_d     = neg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    // A zero operand always gives a positive result, so no negative-zero path exists.
                    neg_d    = (a_neg ^ b_neg) && (a != '0) && (b != '0);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    product_d = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            neg_q     <= neg_d;
        end
    end

    // in_ready is gated by rst so it reads low in reset yet allows acceptance on the first edge after.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: transaction-level reference model compared against the DUT every cycle,
// plus directed literal cases and randomized operand/backpressure traffic.
module tb_seq_shift_add_multiplier;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Exact mathematical product, truncated to 2*W bits.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        longint px, py, pr;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        pr = px * py;
        return pr[PW-1:0];
    endfunction

    // Transaction model: 0 = waiting, 1 = computing, 2 = result offered.
    int            m_state = 0;
    int            m_left  = 0;
    logic [PW-1:0] m_res   = '0;
    logic [PW-1:0] m_prod  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_prod  = '0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_res   = ref_mul(a, b, signed_mode);
                    m_left  = W;
                    m_state = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = 2;
                        m_prod  = m_res;
                    end
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_state == 0 && !rst));
        chk("out_valid", 32'(out_valid), 32'(m_state == 2));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("product", 32'(product), 32'(m_prod));
    end

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                           input int hold, input logic use_exp, input logic [PW-1:0] exp_p);
        int cyc;
        @(negedge clk);
        a = ta; b = tbv; signed_mode = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            a = W'($urandom); b = W'($urandom);
            signed_mode = 1'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(cyc), 32'(W));
        if (use_exp) chk("product_lit", 32'(product), 32'(exp_p));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (use_exp) chk("product_retain", 32'(product), 32'(exp_p));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;

        chk("model_15x15u", 32'(ref_mul(8'd15, 8'd15, 1'b0)), 32'h00E1);
        chk("model_255x255u", 32'(ref_mul(8'hFF, 8'hFF, 1'b0)), 32'hFE01);
        chk("model_80x80s", 32'(ref_mul(8'h80, 8'h80, 1'b1)), 32'h4000);
        chk("model_80x7Fs", 32'(ref_mul(8'h80, 8'h7F, 1'b1)), 32'hC080);
        chk("model_FDx05s", 32'(ref_mul(8'hFD, 8'h05, 1'b1)), 32'hFFF1);
        chk("model_FDx05u", 32'(ref_mul(8'hFD, 8'h05, 1'b0)), 32'h04F1);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_product", 32'(product), 32'h0);
        #2 rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        run_txn(8'd15, 8'd15, 1'b0, 0, 1'b1, 16'h00E1);
        run_txn(8'hFF, 8'hFF, 1'b0, 0, 1'b1, 16'hFE01);
        run_txn(8'h80, 8'h80, 1'b1, 1, 1'b1, 16'h4000);
        run_txn(8'h80, 8'h7F, 1'b1, 0, 1'b1, 16'hC080);
        run_txn(8'hFD, 8'h05, 1'b1, 2, 1'b1, 16'hFFF1);
        run_txn(8'hFD, 8'h05, 1'b0, 0, 1'b1, 16'h04F1);
        run_txn(8'hFB, 8'h00, 1'b1, 0, 1'b1, 16'h0000);
        run_txn(8'h00, 8'h80, 1'b1, 0, 1'b1, 16'h0000);
        run_txn(8'h12, 8'h34, 1'b1, 20, 1'b1, 16'h03A8);

        // Abort in the fourth CALC cycle.
        @(negedge clk);
        a = 8'h55; b = 8'h33; signed_mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h0);
        chk("abort_product", 32'(product), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("abort_release_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_out_valid", 32'(out_valid), 32'h0);
        end
        run_txn(8'd6, 8'd7, 1'b0, 0, 1'b1, 16'h002A);

        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(ra, rb, rs, int'($urandom_range(0, 3)), 1'b1, ref_mul(ra, rb, rs));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
